apd_gate_counter: RTL and testbench

- Consumer side of the APD one-shot interface: takes the single-cycle, dead-time-filtered detection pulses and counts them over a programmable gate window of N clock cycles.
- At the end of each window it presents the count on a valid/ready handshake to the readout/UART path.
- Sits directly downstream of the one-shot, one instance per APD channel.

---
 rtl/apd_pkg.sv | 17 +
 rtl/apd_sat_counter.sv | 48 ++++
 rtl/apd_gate_counter.sv | 102 ++++++++++
 tb/tb_apd_gate_counter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apd_pkg.sv
// Shared definitions for the APD counting path: FSM encoding, default widths
// and the saturation ceiling helper.
package apd_pkg;

   localparam int COUNT_W_DEFAULT = 16;
   localparam int GATE_W_DEFAULT  = 24;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GATE   = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   // All-ones value of a counter of the given width (widths up to 32).
   function automatic logic [31:0] sat_max(input int width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/apd_sat_counter.sv
// Saturating event accumulator with synchronous clear and a sticky flag that
// records any increment dropped at the ceiling.
module apd_sat_counter
   import apd_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEFAULT
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               clear,
   input  logic               inc,
   output logic [COUNT_W-1:0] value_next,
   output logic               ovf_next
);

   localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(sat_max(COUNT_W));

   logic [COUNT_W-1:0] value_reg;
   logic               ovf_reg;

   // The outputs are the look-ahead values, so a parent can capture an event
   // that lands on the same cycle it samples the total.
   always_comb begin
      value_next = value_reg;
      ovf_next   = ovf_reg;
      if (clear) begin
         value_next = '0;
         ovf_next   = 1'b0;
      end else if (inc) begin
         if (value_reg == MAX_VAL) begin
            ovf_next = 1'b1;
         end else begin
            value_next = value_reg + COUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         value_reg <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         value_reg <= value_next;
         ovf_reg   <= ovf_next;
      end
   end

endmodule

// File: rtl/apd_gate_counter.sv
// Counts one-shot detection pulses over a programmable gate window and hands
// each window's total to the readout path over a valid/ready handshake.
module apd_gate_counter
   import apd_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEFAULT,
   parameter int GATE_W  = GATE_W_DEFAULT
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               enable,
   input  logic               pulse,
   input  logic [GATE_W-1:0]  gate_cycles,
   output logic [COUNT_W-1:0] count_out,
   output logic               overflow,
   output logic               count_valid,
   input  logic               count_ready,
   output logic               busy
);

   logic [1:0]         state_reg;
   logic [GATE_W-1:0]  len_reg;
   logic [GATE_W-1:0]  cyc_reg;
   logic [COUNT_W-1:0] count_out_reg;
   logic               overflow_reg;
   logic               valid_reg;

   logic [GATE_W-1:0]  len_load;
   logic               start;
   logic               last;
   logic               acc_inc;
   logic [COUNT_W-1:0] acc_value_next;
   logic               acc_ovf_next;

   // A zero-length gate would never reach len-1, so it runs as one cycle.
   assign len_load = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
   assign start    = enable && ((state_reg == ST_IDLE) ||
                                ((state_reg == ST_REPORT) && valid_reg && count_ready));
   assign last     = (state_reg == ST_GATE) && (cyc_reg == (len_reg - GATE_W'(1)));
   assign acc_inc  = (state_reg == ST_GATE) && pulse;

   apd_sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_acc (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (start),
      .inc        (acc_inc),
      .value_next (acc_value_next),
      .ovf_next   (acc_ovf_next)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         len_reg       <= '0;
         cyc_reg       <= '0;
         count_out_reg <= '0;
         overflow_reg  <= 1'b0;
         valid_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (enable) begin
                  len_reg   <= len_load;
                  cyc_reg   <= '0;
                  state_reg <= ST_GATE;
               end
            end
            ST_GATE: begin
               cyc_reg <= cyc_reg + GATE_W'(1);
               if (last) begin
                  count_out_reg <= acc_value_next;
                  overflow_reg  <= acc_ovf_next;
                  valid_reg     <= 1'b1;
                  state_reg     <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               // Pulses here are deliberately dropped: this is the dead interval.
               if (valid_reg && count_ready) begin
                  valid_reg <= 1'b0;
                  if (enable) begin
                     len_reg   <= len_load;
                     cyc_reg   <= '0;
                     state_reg <= ST_GATE;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign count_out   = count_out_reg;
   assign overflow    = overflow_reg;
   assign count_valid = valid_reg;
   assign busy        = (state_reg == ST_GATE);

endmodule

// File: tb/tb_apd_gate_counter.sv
// Directed bench for apd_gate_counter (4-bit count); results are checked by a
// scoreboard monitor that pops expected values on every handshake.
module tb_apd_gate_counter;

   logic        clock       = 1'b0;
   logic        resetn      = 1'b0;
   logic        enable      = 1'b0;
   logic        pulse       = 1'b0;
   logic        count_ready = 1'b0;
   logic [23:0] gate_cycles = '0;
   logic [3:0]  count_out;
   logic        overflow;
   logic        count_valid;
   logic        busy;

   typedef struct packed {
      logic [3:0] cnt;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks       = 0;
   int   errors       = 0;
   int   valid_cycles = 0;
   int   idle_busy    = 0;

   apd_gate_counter #(
      .COUNT_W (4),
      .GATE_W  (24)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .enable      (enable),
      .pulse       (pulse),
      .gate_cycles (gate_cycles),
      .count_out   (count_out),
      .overflow    (overflow),
      .count_valid (count_valid),
      .count_ready (count_ready),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int cnt, input bit ovf);
      exp_t e;
      e.cnt = cnt[3:0];
      e.ovf = ovf;
      exp_q.push_back(e);
   endtask

   // Drive pulse[i] for window cycle i; the caller has already passed the entry edge.
   task automatic drive_window(input int n, input logic [31:0] pat);
      for (int i = 0; i < n; i++) begin
         pulse = pat[i];
         tick();
      end
      pulse = 1'b0;
   endtask

   initial begin
      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clock);
               if (count_valid) begin
                  valid_cycles++;
                  if (count_ready) begin
                     if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got count %0d ovf %0d, none expected",
                                 count_out, overflow);
                     end else begin
                        e = exp_q.pop_front();
                        check("result_count", 32'(count_out), 32'(e.cnt));
                        check("result_overflow", 32'(overflow), 32'(e.ovf));
                     end
                  end
               end
            end
         end
         begin : stimulus
            // reset with pulse activity
            repeat (3) begin
               pulse = ~pulse;
               tick();
            end
            @(negedge clock);
            check("rst_count_out", 32'(count_out), 0);
            check("rst_overflow", 32'(overflow), 0);
            check("rst_valid", 32'(count_valid), 0);
            check("rst_busy", 32'(busy), 0);
            resetn       = 1'b1;
            valid_cycles = 0;
            repeat (50) begin
               pulse = ~pulse;
               tick();
               if (busy) idle_busy++;
            end
            check("idle_valid_cycles", 32'(valid_cycles), 0);
            check("idle_busy_cycles", 32'(idle_busy), 0);

            // basic window: pulses on cycles 0,3,5,9 plus ignored ones either side
            count_ready  = 1'b1;
            gate_cycles  = 24'd10;
            enable       = 1'b1;
            pulse        = 1'b1;
            valid_cycles = 0;
            push(4, 1'b0);
            tick();
            enable = 1'b0;
            drive_window(10, 32'h229);
            pulse = 1'b1;
            tick();
            pulse = 1'b0;
            repeat (3) tick();
            check("basic_valid_cycles", 32'(valid_cycles), 1);
            check("basic_idle_busy", 32'(busy), 0);

            // back-to-back with 7 cycles of backpressure
            count_ready = 1'b0;
            gate_cycles = 24'd5;
            enable      = 1'b1;
            push(3, 1'b0);
            tick();
            drive_window(5, 32'h0B);
            pulse = 1'b1;
            repeat (7) begin
               @(negedge clock);
               check("bp_valid", 32'(count_valid), 1);
               check("bp_count", 32'(count_out), 3);
               check("bp_busy", 32'(busy), 0);
               tick();
            end
            count_ready = 1'b1;
            push(2, 1'b0);
            tick();
            enable = 1'b0;
            check("bp_restart_busy", 32'(busy), 1);
            drive_window(5, 32'h11);
            tick();
            tick();
            check("bp_end_busy", 32'(busy), 0);

            // saturation then a normal window started straight from REPORT
            gate_cycles = 24'd20;
            enable      = 1'b1;
            push(15, 1'b1);
            tick();
            drive_window(20, 32'hFFFFF);
            gate_cycles = 24'd6;
            pulse       = 1'b1;
            push(3, 1'b0);
            tick();
            enable = 1'b0;
            drive_window(6, 32'h2A);
            tick();
            tick();

            // gate lengths 0 and 1 both run a single cycle
            gate_cycles = 24'd0;
            enable      = 1'b1;
            push(1, 1'b0);
            tick();
            enable = 1'b0;
            drive_window(1, 32'h1);
            @(negedge clock);
            check("gate0_valid", 32'(count_valid), 1);
            tick();
            gate_cycles = 24'd1;
            enable      = 1'b1;
            push(1, 1'b0);
            tick();
            enable = 1'b0;
            drive_window(1, 32'h1);
            @(negedge clock);
            check("gate1_valid", 32'(count_valid), 1);
            tick();

            // gate_cycles change mid-window must not shorten it
            gate_cycles = 24'd8;
            enable      = 1'b1;
            push(8, 1'b0);
            tick();
            enable      = 1'b0;
            gate_cycles = 24'd2;
            drive_window(8, 32'hFF);
            @(negedge clock);
            check("midchange_valid", 32'(count_valid), 1);
            tick();
            tick();

            // reset in the middle of a window
            gate_cycles = 24'd10;
            enable      = 1'b1;
            tick();
            enable = 1'b0;
            drive_window(4, 32'hF);
            check("mg_busy_before", 32'(busy), 1);
            resetn = 1'b0;
            tick();
            check("mg_busy_after", 32'(busy), 0);
            check("mg_valid_after", 32'(count_valid), 0);
            check("mg_count_after", 32'(count_out), 0);
            resetn      = 1'b1;
            gate_cycles = 24'd3;
            enable      = 1'b1;
            push(3, 1'b0);
            tick();
            enable = 1'b0;
            drive_window(3, 32'h7);
            tick();
            tick();

            // reset while a result is waiting; that result is discarded
            count_ready = 1'b0;
            gate_cycles = 24'd4;
            enable      = 1'b1;
            tick();
            enable = 1'b0;
            drive_window(4, 32'hF);
            @(negedge clock);
            check("rv_valid_before", 32'(count_valid), 1);
            check("rv_count_before", 32'(count_out), 4);
            resetn = 1'b0;
            tick();
            check("rv_valid_after", 32'(count_valid), 0);
            check("rv_count_after", 32'(count_out), 0);
            check("rv_overflow_after", 32'(overflow), 0);
            check("rv_busy_after", 32'(busy), 0);
            resetn      = 1'b1;
            count_ready = 1'b1;
            gate_cycles = 24'd2;
            enable      = 1'b1;
            push(1, 1'b0);
            tick();
            enable = 1'b0;
            drive_window(2, 32'h1);
            tick();
            tick();
            check("queue_drained", 32'(exp_q.size()), 0);
         end
         begin : watchdog
            #100000;
            checks++;
            errors++;
            $display("FAIL timeout: stimulus did not complete, %0d results outstanding", exp_q.size());
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
